// File: rtl/mux_8_1_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_8_1_rr : registered 8-to-1 round-robin lane multiplexer              |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module mux_8_1_rr #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*DATA_W-1:0] in_data,
  input  logic [7:0]          in_valid,
  output logic [7:0]          in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [2:0]        out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [2:0]        ptr_q, ptr_d;

  logic              w_load;
  logic              w_found;
  logic [2:0]        w_grant;
  logic [2:0]        w_idx;
  logic [DATA_W-1:0] w_grant_data;

  assign w_load = ~out_valid_q | out_ready;

  // First valid lane at or after the pointer; the 3-bit add wraps 7 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_grant = 3'd0;
    w_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_idx = ptr_q + 3'(i);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (w_grant == 3'(k)) begin
        w_grant_data = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    in_ready = 8'h00;
    if (!rst && w_load && w_found) begin
      in_ready = 8'h01 << w_grant;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (w_load) begin
      if (w_found) begin
        out_data_d  = w_grant_data;
        out_sel_d   = w_grant;
        out_valid_d = 1'b1;
        ptr_d       = w_grant + 3'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= 3'd0;
      out_valid_q <= 1'b0;
      ptr_q       <= 3'd0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_8_1_rr.sv
`default_nettype none
// Bench for mux_8_1_rr: directed scenarios then random traffic, compared
// against a cycle-level behavioural model of the round-robin gatherer.
module tb_mux_8_1_rr;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [8*DATA_W-1:0] in_data;
  logic [7:0]          in_valid;
  logic [7:0]          in_ready;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_sel;
  logic                out_valid;
  logic                out_ready;

  int checks = 0;
  int passed = 0;

  // behavioural model state
  int   m_ptr;
  logic m_valid;
  int   m_sel;
  int   m_data;

  mux_8_1_rr #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input logic r, input logic [7:0] v, input logic [63:0] d, input logic ordy);
    int   g;
    logic load;
    logic [7:0] exp_rdy;
    logic [7:0] demux;
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g = -1;
    load = !m_valid || ordy;
    if (!r && load) begin
      for (int off = 0; off < 8; off++) begin
        if (g < 0 && v[(m_ptr + off) % 8]) g = (m_ptr + off) % 8;
      end
    end
    exp_rdy = (g >= 0) ? (8'h01 << g) : 8'h00;
    chk("in_ready", {24'd0, in_ready}, {24'd0, exp_rdy});
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_sel = g; m_data = int'(d[g*8 +: 8]); m_ptr = (g + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_sel",   {29'd0, out_sel},   32'(m_sel));
    chk("out_data",  {24'd0, out_data},  32'(m_data));
    if (m_valid) begin
      // a downstream 1-to-8 demux carrying bit 0 of each beat
      demux = 8'h00;
      demux[out_sel] = out_data[0];
      chk("loopback", {24'd0, demux}, {24'd0, 8'(m_data[0]) << m_sel});
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] lane_fill(input int base);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(base + k);
    return d;
  endfunction

  initial begin
    logic [63:0] d;
    logic [7:0]  v;
    m_ptr = 0; m_valid = 1'b0; m_sel = 0; m_data = 0;
    rst = 1'b1; in_valid = 8'h00; in_data = '0; out_ready = 1'b1;
    @(negedge clk);

    // reset with every lane valid, then first grant must be lane 0
    d = lane_fill(8'h30);
    step(1'b1, 8'hFF, d, 1'b1);
    step(1'b1, 8'hFF, d, 1'b1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'hFF, d, 1'b1);
    chk("first_grant", {29'd0, out_sel}, 32'd0);
    step(1'b0, 8'h00, d, 1'b1);

    // single lane 5
    step(1'b1, 8'h00, d, 1'b1);
    d = '0; d[5*8 +: 8] = 8'hA5;
    step(1'b0, 8'h20, d, 1'b1);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    chk("single_sel",  {29'd0, out_sel},  32'd5);
    step(1'b0, 8'h00, d, 1'b1);
    chk("single_drain", {31'd0, out_valid}, 32'd0);

    // round-robin wrap, no bubbles
    step(1'b1, 8'h00, d, 1'b1);
    d = lane_fill(8'h10);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'hFF, d, 1'b1);
      chk("rr_sel",  {29'd0, out_sel},  32'(i % 8));
      chk("rr_data", {24'd0, out_data}, 32'(8'h10 + (i % 8)));
    end

    // backpressure: lane 2 loads and holds, lane 6 follows
    step(1'b1, 8'h00, d, 1'b1);
    step(1'b0, 8'h44, d, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h40, d, 1'b0);
      chk("bp_hold_sel", {29'd0, out_sel}, 32'd2);
    end
    step(1'b0, 8'h40, d, 1'b1);
    chk("bp_next_sel",   {29'd0, out_sel}, 32'd6);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 8'h00, d, 1'b1);

    // reset while holding lane 4 under backpressure
    step(1'b1, 8'h00, d, 1'b1);
    step(1'b0, 8'h10, d, 1'b1);
    step(1'b0, 8'h00, d, 1'b0);
    step(1'b1, 8'h00, d, 1'b0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'h88, d, 1'b1);
    chk("midrst_grant", {29'd0, out_sel}, 32'd3);

    // random traffic with loopback checks
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      v = 8'($urandom);
      step(($urandom_range(0, 49) == 0), v, d, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
